branch_predict_ctrl: RTL and testbench

- Direction predictor and mispredict-recovery sequencer for the 3-stage pipeline's branch path.
- In IF it predicts conditional branches from a table of 2-bit saturating counters.
- In EX it compares the branch-condition result with the carried prediction. On mismatch it issues a PC redirect and sequences the flush of wrong-path instructions.
- It owns no datapath. It drives the PC mux and the pipeline-register flush controls.

---
 rtl/branch_pkg.sv | 18 +
 rtl/bht_2bit.sv | 36 +++
 rtl/branch_predict_ctrl.sv | 121 ++++++++++++
 tb/tb_branch_predict_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared branch definitions: branch-type encoding and 2-bit counter constants.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4,
        BR_LTU  = 3'd5,
        BR_GEU  = 3'd6,
        BR_JUMP = 3'd7
    } br_type_e;

    localparam logic [1:0] CTR_INIT = 2'b01;
    localparam logic [1:0] CTR_MAX  = 2'b11;

endpackage

// File: rtl/bht_2bit.sv
// Branch history table: 2-bit saturating counters, one async read port,
// one registered update port. Read returns the pre-edge value (no bypass).
module bht_2bit
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);

    logic [1:0] r_ctr [BHT_ENTRIES];
    logic [1:0] w_cur;

    assign o_rd_ctr = r_ctr[i_rd_idx];
    assign w_cur    = r_ctr[i_upd_idx];

    // Saturating counter update; all entries reset to weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_ctr[i] <= CTR_INIT;
        end else if (i_upd_en) begin
            if (i_upd_taken && w_cur != CTR_MAX)
                r_ctr[i_upd_idx] <= w_cur + 2'd1;
            else if (!i_upd_taken && w_cur != 2'b00)
                r_ctr[i_upd_idx] <= w_cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Direction predictor and mispredict-recovery sequencer for the branch path.
// Predicts in IF from the BHT, resolves in EX, redirects the PC and holds
// pipeline flushes for 1+FLUSH_CYCLES cycles on a mispredict.
module branch_predict_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic            if_is_cond_br,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic [2:0]      ex_branch_type,
    input  logic            ex_branch_taken,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if,
    output logic            flush_ex,
    output logic            recovering,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int         IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [2:0] FC    = 3'(FLUSH_CYCLES);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RECOVER = 1'b1} state_e;

    state_e           r_state, w_state_nx;
    logic [2:0]       r_down, w_down_nx;
    logic [CNT_W-1:0] r_cnt;

    logic [IDX_W-1:0] w_if_idx, w_ex_idx;
    logic [1:0]       w_rd_ctr;
    br_type_e         w_type;
    logic             w_is_cond, w_is_jump, w_act, w_mispredict, w_upd_en;

    // Index from word-aligned PC; the shift keeps the full PC visible to lint.
    assign w_if_idx = IDX_W'(if_pc >> 2);
    assign w_ex_idx = IDX_W'(ex_pc >> 2);

    bht_2bit #(.BHT_ENTRIES(BHT_ENTRIES), .IDX_W(IDX_W)) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_idx    (w_if_idx),
        .o_rd_ctr    (w_rd_ctr),
        .i_upd_en    (w_upd_en),
        .i_upd_idx   (w_ex_idx),
        .i_upd_taken (ex_branch_taken)
    );

    // Resolve, redirect/flush outputs and FSM next state.
    always_comb begin
        w_type         = br_type_e'(ex_branch_type);
        w_is_cond      = (w_type != BR_NONE) && (w_type != BR_JUMP);
        w_is_jump      = (w_type == BR_JUMP);
        w_act          = rst_n && (r_state == ST_IDLE) && ex_valid;
        w_mispredict   = w_act && (w_is_cond ? (ex_branch_taken != ex_pred_taken) : w_is_jump);
        w_upd_en       = w_act && w_is_cond;
        if_pred_taken  = rst_n && if_valid && if_is_cond_br && w_rd_ctr[1];
        redirect_valid = w_mispredict;
        redirect_pc    = '0;
        if (w_mispredict)
            redirect_pc = (w_is_cond && !ex_branch_taken) ? ex_pc + XLEN'(4) : ex_target;
        recovering     = rst_n && (r_state == ST_RECOVER);
        flush_if       = w_mispredict || recovering;
        flush_ex       = w_mispredict || recovering;
        w_state_nx     = r_state;
        w_down_nx      = r_down;
        case (r_state)
            ST_IDLE: begin
                if (w_mispredict && FC != 3'd0) begin
                    w_state_nx = ST_RECOVER;
                    w_down_nx  = FC;
                end
            end
            ST_RECOVER: begin
                if (r_down <= 3'd1) begin
                    w_state_nx = ST_IDLE;
                    w_down_nx  = 3'd0;
                end else begin
                    w_down_nx  = r_down - 3'd1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_down_nx  = 3'd0;
            end
        endcase
    end

    // FSM state and flush down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_down  <= 3'd0;
        end else begin
            r_state <= w_state_nx;
            r_down  <= w_down_nx;
        end
    end

    // Saturating mispredict statistics counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_mispredict && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
    end

    assign mispredict_cnt = r_cnt;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: three instances (FLUSH_CYCLES 0/1/3) share
// stimulus; a behavioural model checks every cycle, plus a directed table
// for the FLUSH_CYCLES=1 instance and hand sequences for recovery/reset.
module tb_branch_predict_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, if_valid, if_is_cond_br, ex_valid, ex_branch_taken, ex_pred_taken;
    logic [31:0] if_pc, ex_pc, ex_target;
    logic [2:0]  ex_branch_type;

    logic [2:0]        p, rv, fi, fe, rc;
    logic [2:0][31:0]  rpc;
    logic [2:0][15:0]  mc;

    branch_predict_ctrl #(.FLUSH_CYCLES(0)) u0 (.clk(clk), .rst_n(rst_n), .if_valid(if_valid),
        .if_is_cond_br(if_is_cond_br), .if_pc(if_pc), .if_pred_taken(p[0]), .ex_valid(ex_valid),
        .ex_branch_type(ex_branch_type), .ex_branch_taken(ex_branch_taken), .ex_pred_taken(ex_pred_taken),
        .ex_pc(ex_pc), .ex_target(ex_target), .redirect_valid(rv[0]), .redirect_pc(rpc[0]),
        .flush_if(fi[0]), .flush_ex(fe[0]), .recovering(rc[0]), .mispredict_cnt(mc[0]));
    branch_predict_ctrl #(.FLUSH_CYCLES(1)) u1 (.clk(clk), .rst_n(rst_n), .if_valid(if_valid),
        .if_is_cond_br(if_is_cond_br), .if_pc(if_pc), .if_pred_taken(p[1]), .ex_valid(ex_valid),
        .ex_branch_type(ex_branch_type), .ex_branch_taken(ex_branch_taken), .ex_pred_taken(ex_pred_taken),
        .ex_pc(ex_pc), .ex_target(ex_target), .redirect_valid(rv[1]), .redirect_pc(rpc[1]),
        .flush_if(fi[1]), .flush_ex(fe[1]), .recovering(rc[1]), .mispredict_cnt(mc[1]));
    branch_predict_ctrl #(.FLUSH_CYCLES(3)) u3 (.clk(clk), .rst_n(rst_n), .if_valid(if_valid),
        .if_is_cond_br(if_is_cond_br), .if_pc(if_pc), .if_pred_taken(p[2]), .ex_valid(ex_valid),
        .ex_branch_type(ex_branch_type), .ex_branch_taken(ex_branch_taken), .ex_pred_taken(ex_pred_taken),
        .ex_pc(ex_pc), .ex_target(ex_target), .redirect_valid(rv[2]), .redirect_pc(rpc[2]),
        .flush_if(fi[2]), .flush_ex(fe[2]), .recovering(rc[2]), .mispredict_cnt(mc[2]));

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Behavioural model: counters as integers, flush as cycles remaining.
    int fl[3] = '{0, 1, 3};
    int bht[3][16];
    int rem[3];
    int mcnt[3];
    bit m_mis[3], m_upd[3];

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) bht[k][i] = 1;
            rem[k]  = 0;
            mcnt[k] = 0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            bit cond, ep, efl, erec;
            logic [31:0] erpc;
            cond = (ex_branch_type >= 3'd1) && (ex_branch_type <= 3'd6);
            ep   = if_valid && if_is_cond_br && (bht[k][idx(if_pc)] >= 2);
            erpc = 32'h0;
            if (rem[k] > 0) begin
                m_mis[k] = 0; m_upd[k] = 0; efl = 1; erec = 1;
            end else begin
                m_mis[k] = ex_valid && (cond ? (ex_branch_taken != ex_pred_taken) : (ex_branch_type == 3'd7));
                m_upd[k] = ex_valid && cond;
                efl = m_mis[k]; erec = 0;
                erpc = (cond && !ex_branch_taken) ? ex_pc + 32'd4 : ex_target;
            end
            chk($sformatf("u%0d.pred", k), 32'(p[k]), 32'(ep));
            chk($sformatf("u%0d.redirect_valid", k), 32'(rv[k]), 32'(m_mis[k]));
            chk($sformatf("u%0d.flush_if", k), 32'(fi[k]), 32'(efl));
            chk($sformatf("u%0d.flush_ex", k), 32'(fe[k]), 32'(efl));
            chk($sformatf("u%0d.recovering", k), 32'(rc[k]), 32'(erec));
            chk($sformatf("u%0d.mispredict_cnt", k), 32'(mc[k]), mcnt[k]);
            if (m_mis[k]) chk($sformatf("u%0d.redirect_pc", k), rpc[k], erpc);
        end
    endtask

    task automatic commit();
        for (int k = 0; k < 3; k++) begin
            int e;
            e = idx(ex_pc);
            if (m_upd[k]) bht[k][e] = ex_branch_taken ? ((bht[k][e] < 3) ? bht[k][e] + 1 : 3)
                                                      : ((bht[k][e] > 0) ? bht[k][e] - 1 : 0);
            if (rem[k] > 0) rem[k]--;
            else if (m_mis[k]) begin
                if (mcnt[k] < 65535) mcnt[k]++;
                rem[k] = fl[k];
            end
        end
    endtask

    // Called #2 after a negedge with inputs stable; returns at the next negedge.
    task automatic cycle();
        check_all();
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    task automatic set_in(input logic ifv, input logic [31:0] ipc, input logic exv, input logic [2:0] t,
                          input logic tk, input logic pr, input logic [31:0] epc, input logic [31:0] tgt);
        if_valid = ifv; if_is_cond_br = ifv; if_pc = ipc;
        ex_valid = exv; ex_branch_type = t; ex_branch_taken = tk; ex_pred_taken = pr;
        ex_pc = epc; ex_target = tgt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic ifv; logic [31:0] ifpc; logic exv; logic [2:0] typ; logic tk, pr;
        logic [31:0] expc, tgt;
        logic e_p, e_rv; logic [31:0] e_rpc; logic e_fl, e_rec; logic [15:0] e_cnt;
    } vec_t;

    vec_t tab[18];

    initial begin
        // Directed vectors for the FLUSH_CYCLES=1 instance, starting from reset.
        tab[0]  = '{1, 32'h40, 0, 0, 0, 0, 32'h0, 32'h0,   0, 0, 32'h0,   0, 0, 16'd0};
        tab[1]  = '{1, 32'h40, 1, 1, 1, 0, 32'h40, 32'h100, 0, 1, 32'h100, 1, 0, 16'd0};
        tab[2]  = '{1, 32'h40, 0, 0, 0, 0, 32'h0, 32'h0,   1, 0, 32'h0,   1, 1, 16'd1};
        tab[3]  = '{1, 32'h40, 1, 2, 0, 1, 32'h80, 32'h200, 1, 1, 32'h84,  1, 0, 16'd1};
        tab[4]  = '{1, 32'h40, 0, 0, 0, 0, 32'h0, 32'h0,   0, 0, 32'h0,   1, 1, 16'd2};
        for (int i = 5; i <= 9; i++)
            tab[i] = '{1, 32'h40, 1, 1, 0, 0, 32'h40, 32'h100, 0, 0, 32'h0, 0, 0, 16'd2};
        tab[10] = '{1, 32'h40, 0, 0, 0, 0, 32'h0, 32'h0,   0, 0, 32'h0,   0, 0, 16'd2};
        tab[11] = '{1, 32'hFFFF_FFFC, 1, 7, 1, 0, 32'hFFFF_FFFC, 32'h8, 0, 1, 32'h8, 1, 0, 16'd2};
        tab[12] = '{1, 32'h7C, 0, 0, 0, 0, 32'h0, 32'h0,   0, 0, 32'h0,   1, 1, 16'd3};
        tab[13] = '{0, 32'h0, 1, 1, 0, 1, 32'hFFFF_FFFC, 32'h1234, 0, 1, 32'h0, 1, 0, 16'd3};
        tab[14] = '{0, 32'h0, 1, 3, 1, 0, 32'h10, 32'h20,   0, 0, 32'h0,   1, 1, 16'd4};
        tab[15] = '{0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0,    0, 0, 32'h0,   0, 0, 16'd4};
        tab[16] = '{1, 32'h44, 1, 1, 1, 1, 32'h44, 32'h300, 0, 0, 32'h0,   0, 0, 16'd4};
        tab[17] = '{1, 32'h44, 0, 0, 0, 0, 32'h0, 32'h0,   1, 0, 32'h0,   0, 0, 16'd4};

        // Reset state
        set_in(1, 32'h40, 1, 3'd7, 1, 0, 32'h0, 32'h8);
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst.u%0d.redirect_valid", k), 32'(rv[k]), 0);
            chk($sformatf("rst.u%0d.flush", k), 32'(fi[k] | fe[k]), 0);
            chk($sformatf("rst.u%0d.recovering", k), 32'(rc[k]), 0);
            chk($sformatf("rst.u%0d.cnt", k), 32'(mc[k]), 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table phase
        for (int i = 0; i < 18; i++) begin
            set_in(tab[i].ifv, tab[i].ifpc, tab[i].exv, tab[i].typ, tab[i].tk, tab[i].pr, tab[i].expc, tab[i].tgt);
            #2;
            chk($sformatf("tab%0d.pred", i), 32'(p[1]), 32'(tab[i].e_p));
            chk($sformatf("tab%0d.redirect_valid", i), 32'(rv[1]), 32'(tab[i].e_rv));
            if (tab[i].e_rv) chk($sformatf("tab%0d.redirect_pc", i), rpc[1], tab[i].e_rpc);
            chk($sformatf("tab%0d.flush", i), 32'({fi[1], fe[1]}), tab[i].e_fl ? 32'd3 : 32'd0);
            chk($sformatf("tab%0d.recovering", i), 32'(rc[1]), 32'(tab[i].e_rec));
            chk($sformatf("tab%0d.cnt", i), 32'(mc[1]), 32'(tab[i].e_cnt));
            cycle();
        end

        // FLUSH_CYCLES=3: mispredicting BLTs during RECOVER are ignored
        do_reset();
        set_in(0, 32'h0, 1, 3'd3, 0, 1, 32'h48, 32'h200);
        #2;
        chk("f3.T.redirect_valid", 32'(rv[2]), 1);
        chk("f3.T.redirect_pc", rpc[2], 32'h4C);
        chk("f3.T.flush", 32'({fi[2], fe[2]}), 3);
        cycle();
        for (int c = 1; c <= 3; c++) begin
            set_in(0, 32'h0, 1, 3'd3, 1, 0, 32'h48, 32'h200);
            #2;
            chk($sformatf("f3.rec%0d.redirect_valid", c), 32'(rv[2]), 0);
            chk($sformatf("f3.rec%0d.flush", c), 32'({fi[2], fe[2]}), 3);
            chk($sformatf("f3.rec%0d.recovering", c), 32'(rc[2]), 1);
            cycle();
        end
        set_in(1, 32'h48, 0, 3'd0, 0, 0, 32'h0, 32'h0);
        #2;
        chk("f3.end.recovering", 32'(rc[2]), 0);
        chk("f3.end.flush", 32'({fi[2], fe[2]}), 0);
        chk("f3.end.pred", 32'(p[2]), 0);
        chk("f3.end.cnt", 32'(mc[2]), 1);
        cycle();

        // Reset asserted in the 2nd RECOVER cycle aborts the flush
        do_reset();
        set_in(0, 32'h0, 1, 3'd3, 1, 0, 32'h48, 32'h200);
        #2;
        cycle();
        set_in(1, 32'h48, 0, 3'd0, 0, 0, 32'h0, 32'h0);
        #2;
        cycle();
        #2;
        chk("rstmid.before.recovering", 32'(rc[2]), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid.pred", 32'(p[2]), 0);
        chk("rstmid.redirect_valid", 32'(rv[2]), 0);
        chk("rstmid.redirect_pc", rpc[2], 0);
        chk("rstmid.flush", 32'({fi[2], fe[2]}), 0);
        chk("rstmid.recovering", 32'(rc[2]), 0);
        chk("rstmid.cnt", 32'(mc[2]), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 32'h0, 0, 3'd0, 0, 0, 32'h0, 32'h0);
        #2;
        chk("rstmid.after.recovering", 32'(rc[2]), 0);
        chk("rstmid.after.flush", 32'({fi[2], fe[2]}), 0);
        cycle();

        // Randomized phase against the model
        for (int n = 0; n < 600; n++) begin
            if_valid       = ($urandom % 4) != 0;
            if_is_cond_br  = ($urandom % 3) != 0;
            if_pc          = ($urandom % 5 == 0) ? 32'hFFFF_FFFC : (($urandom & 32'hFFFF_FF00) | (32'($urandom % 16) << 2));
            ex_valid       = ($urandom % 4) != 0;
            ex_branch_type = 3'($urandom % 8);
            ex_branch_taken = 1'($urandom);
            ex_pred_taken  = 1'($urandom);
            ex_pc          = ($urandom % 6 == 0) ? 32'hFFFF_FFFC : (($urandom & 32'hFFFF_FF00) | (32'($urandom % 16) << 2));
            ex_target      = $urandom;
            #2;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
